// File: rtl/dma_arb_pkg.sv
// Shared types and constants for the DMA/CPU bus arbiter.
package dma_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } arb_state_e;

  localparam int unsigned REQ_CPU    = 0;
  localparam int unsigned REQ_DMA_RX = 1;
  localparam int unsigned REQ_DMA_TX = 2;

  function automatic int unsigned id_width(input int unsigned num_req);
    return (num_req > 2) ? $clog2(num_req) : 1;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin pick: first requester after last_i, wrapping, wins.
module rr_priority_picker
  import dma_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3,
  localparam int unsigned ID_W = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    last_i,
  output logic [NUM_REQ-1:0] onehot_o,
  output logic [ID_W-1:0]    idx_o,
  output logic               valid_o
);

  logic [ID_W-1:0] cand;
  logic            found;

  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    found    = 1'b0;
    cand     = '0;
    // The previous owner is visited last, so it only wins when alone.
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = ID_W'((32'(last_i) + 32'd1 + i) % NUM_REQ);
      if (!found && req_i[cand]) begin
        found          = 1'b1;
        idx_o          = cand;
        onehot_o[cand] = 1'b1;
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/dma_bus_arbiter.sv
// Round-robin bus arbiter with hold-until-release grants, bounded-hold preemption
// and a one-cycle turnaround between owners.
module dma_bus_arbiter
  import dma_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 3,
  parameter int unsigned MAX_HOLD = 16,
  localparam int unsigned ID_W = id_width(NUM_REQ)
) (
  input  logic               i_Clock,
  input  logic               i_Reset,
  input  logic [NUM_REQ-1:0] i_Req,
  input  logic [NUM_REQ-1:0] i_Done,
  output logic [NUM_REQ-1:0] o_Grant,
  output logic               o_Grant_Valid,
  output logic [ID_W-1:0]    o_Grant_Id,
  output logic [NUM_REQ-1:0] o_Preempt
);

  localparam int unsigned     CNT_W      = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [CNT_W-1:0] HOLD_MAX  = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
  localparam bit              PREEMPT_EN = (MAX_HOLD != 0);

  arb_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ID_W-1:0]    last_q, last_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] preempt_q, preempt_d;
  logic               valid_q;

  logic [NUM_REQ-1:0] pick_onehot;
  logic [ID_W-1:0]    pick_idx;
  logic               pick_valid;

  logic own_done, own_req, others_req, hold_expired;

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .req_i    (i_Req),
    .last_i   (last_q),
    .onehot_o (pick_onehot),
    .idx_o    (pick_idx),
    .valid_o  (pick_valid)
  );

  assign own_done     = |(i_Done & grant_q);
  assign own_req      = |(i_Req & grant_q);
  assign others_req   = |(i_Req & ~grant_q);
  // Saturated counter stays at HOLD_MAX, so a late competitor still preempts.
  assign hold_expired = PREEMPT_EN && ((cnt_q == HOLD_LAST) || (cnt_q == HOLD_MAX));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    id_d      = id_q;
    grant_d   = grant_q;
    preempt_d = '0;
    unique case (state_q)
      ST_IDLE, ST_RELEASE: begin
        grant_d = '0;
        if (pick_valid) begin
          grant_d = pick_onehot;
          id_d    = pick_idx;
          last_d  = pick_idx;
          cnt_d   = '0;
          state_d = ST_GRANT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GRANT: begin
        cnt_d = (cnt_q == HOLD_MAX) ? cnt_q : cnt_q + 1'b1;
        if (own_done || !own_req) begin
          grant_d = '0;
          state_d = ST_RELEASE;
        end else if (hold_expired && others_req) begin
          preempt_d = grant_q;
          grant_d   = '0;
          state_d   = ST_RELEASE;
        end
      end
      default: begin
        grant_d = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      last_q    <= ID_W'(NUM_REQ - 1);
      id_q      <= '0;
      grant_q   <= '0;
      preempt_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      id_q      <= id_d;
      grant_q   <= grant_d;
      preempt_q <= preempt_d;
      valid_q   <= |grant_d;
    end
  end

  assign o_Grant       = grant_q;
  assign o_Grant_Valid = valid_q;
  assign o_Grant_Id    = id_q;
  assign o_Preempt     = preempt_q;

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Directed bench for dma_bus_arbiter with a transaction-level reference model.
module tb_dma_bus_arbiter;

  localparam int N    = 3;
  localparam int MAXH = 8;

  logic         i_Clock = 1'b0;
  logic         i_Reset;
  logic [N-1:0] i_Req;
  logic [N-1:0] i_Done;
  logic [N-1:0] o_Grant;
  logic         o_Grant_Valid;
  logic [1:0]   o_Grant_Id;
  logic [N-1:0] o_Preempt;

  int checks = 0;
  int errors = 0;

  dma_bus_arbiter #(
    .NUM_REQ  (N),
    .MAX_HOLD (MAXH)
  ) dut (
    .i_Clock       (i_Clock),
    .i_Reset       (i_Reset),
    .i_Req         (i_Req),
    .i_Done        (i_Done),
    .o_Grant       (o_Grant),
    .o_Grant_Valid (o_Grant_Valid),
    .o_Grant_Id    (o_Grant_Id),
    .o_Preempt     (o_Preempt)
  );

  always #5 i_Clock = ~i_Clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: owner index (-1 = bus free), cycles held, last winner.
  int           m_owner = -1;
  int           m_held  = 0;
  int           m_last  = N - 1;
  int           m_id    = 0;
  logic [N-1:0] m_pre   = '0;
  bit           m_init  = 1'b0;

  function automatic int rr_pick(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++) begin
      if (r[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  // Inputs change only just after posedge, so at negedge they are what the next edge samples.
  always @(negedge i_Clock) begin
    logic [N-1:0] eg;
    int           w;
    if (m_init) begin
      eg = '0;
      if (m_owner >= 0) eg[m_owner] = 1'b1;
      chk("cyc_grant", 32'(o_Grant), 32'(eg));
      chk("cyc_valid", 32'(o_Grant_Valid), 32'(m_owner >= 0));
      chk("cyc_id", 32'(o_Grant_Id), 32'(m_id));
      chk("cyc_preempt", 32'(o_Preempt), 32'(m_pre));
    end
    if (i_Reset) begin
      m_owner = -1; m_held = 0; m_last = N - 1; m_id = 0; m_pre = '0; m_init = 1'b1;
    end else if (m_init) begin
      m_pre = '0;
      if (m_owner >= 0) begin
        if (i_Done[m_owner] || !i_Req[m_owner]) begin
          m_owner = -1;
        end else if (m_held >= MAXH - 1 && (i_Req & ~(N'(1) << m_owner)) != '0) begin
          m_pre[m_owner] = 1'b1;
          m_owner = -1;
        end else begin
          m_held++;
        end
      end else begin
        w = rr_pick(i_Req, m_last);
        if (w >= 0) begin
          m_owner = w; m_last = w; m_id = w; m_held = 0;
        end
      end
    end
  end

  task automatic drive(input logic [N-1:0] req, input logic [N-1:0] done);
    i_Req  = req;
    i_Done = done;
    @(posedge i_Clock);
    #1;
  endtask

  task automatic do_reset();
    i_Reset = 1'b1;
    drive('0, '0);
    drive('0, '0);
    i_Reset = 1'b0;
  endtask

  initial begin
    i_Reset = 1'b1;
    i_Req   = '0;
    i_Done  = '0;

    // 1: reset state, single requester, release to idle
    do_reset();
    chk("rst_grant", 32'(o_Grant), 32'h0);
    chk("rst_valid", 32'(o_Grant_Valid), 32'h0);
    chk("rst_id", 32'(o_Grant_Id), 32'h0);
    chk("rst_preempt", 32'(o_Preempt), 32'h0);
    drive(3'b010, 3'b000);
    chk("t1_grant", 32'(o_Grant), 32'h2);
    chk("t1_id", 32'(o_Grant_Id), 32'h1);
    drive(3'b000, 3'b010);
    chk("t1_rel", 32'(o_Grant), 32'h0);
    drive(3'b000, 3'b000);
    chk("t1_idle", 32'(o_Grant_Valid), 32'h0);

    // 2: simultaneous 0 and 2, round-robin handover with turnaround
    do_reset();
    drive(3'b101, 3'b000);
    chk("t2_first", 32'(o_Grant), 32'h1);
    drive(3'b101, 3'b001);
    chk("t2_gap1", 32'(o_Grant), 32'h0);
    drive(3'b101, 3'b000);
    chk("t2_second", 32'(o_Grant), 32'h4);
    chk("t2_second_id", 32'(o_Grant_Id), 32'h2);
    drive(3'b101, 3'b000);
    chk("t2_hold", 32'(o_Grant), 32'h4);
    drive(3'b101, 3'b100);
    chk("t2_gap2", 32'(o_Grant), 32'h0);
    drive(3'b001, 3'b000);
    chk("t2_third", 32'(o_Grant), 32'h1);
    drive(3'b000, 3'b001);
    drive(3'b000, 3'b000);

    // 3: timeout preemption of requester 1 by requester 2
    do_reset();
    drive(3'b010, 3'b000);
    drive(3'b010, 3'b000);
    drive(3'b010, 3'b000);
    for (int k = 4; k <= 8; k++) drive(3'b110, 3'b000);
    chk("t3_gc8_grant", 32'(o_Grant), 32'h2);
    chk("t3_gc8_nopre", 32'(o_Preempt), 32'h0);
    drive(3'b110, 3'b000);
    chk("t3_preempt", 32'(o_Preempt), 32'h2);
    chk("t3_pre_gap", 32'(o_Grant), 32'h0);
    drive(3'b110, 3'b000);
    chk("t3_new_owner", 32'(o_Grant), 32'h4);
    chk("t3_pulse_end", 32'(o_Preempt), 32'h0);
    drive(3'b110, 3'b100);
    drive(3'b010, 3'b000);
    chk("t3_regrant", 32'(o_Grant), 32'h2);
    drive(3'b000, 3'b010);
    drive(3'b000, 3'b000);

    // 4: lone owner keeps grant past MAX_HOLD, late competitor preempts at once
    do_reset();
    for (int k = 1; k <= 40; k++) begin
      drive(3'b001, 3'b000);
      chk("t4_keep", 32'(o_Grant), 32'h1);
      chk("t4_nopre", 32'(o_Preempt), 32'h0);
    end
    drive(3'b011, 3'b000);
    chk("t4_preempt", 32'(o_Preempt), 32'h1);
    drive(3'b011, 3'b000);
    chk("t4_next", 32'(o_Grant), 32'h2);
    drive(3'b000, 3'b010);
    drive(3'b000, 3'b000);

    // 5: done coincides with timeout -> normal release, no preempt
    do_reset();
    drive(3'b010, 3'b000);
    for (int k = 2; k <= 8; k++) drive(3'b110, 3'b000);
    drive(3'b110, 3'b010);
    chk("t5_nopre", 32'(o_Preempt), 32'h0);
    chk("t5_gap", 32'(o_Grant), 32'h0);
    drive(3'b100, 3'b000);
    chk("t5_handover", 32'(o_Grant), 32'h4);
    drive(3'b000, 3'b100);
    drive(3'b000, 3'b000);

    // 6: reset during grant of requester 2
    do_reset();
    drive(3'b111, 3'b000);
    drive(3'b111, 3'b001);
    drive(3'b111, 3'b000);
    chk("t6_own1", 32'(o_Grant), 32'h2);
    drive(3'b111, 3'b010);
    drive(3'b111, 3'b000);
    chk("t6_own2", 32'(o_Grant), 32'h4);
    i_Reset = 1'b1;
    drive(3'b111, 3'b000);
    chk("t6_rst_grant", 32'(o_Grant), 32'h0);
    chk("t6_rst_valid", 32'(o_Grant_Valid), 32'h0);
    chk("t6_rst_id", 32'(o_Grant_Id), 32'h0);
    i_Reset = 1'b0;
    drive(3'b111, 3'b000);
    chk("t6_restart", 32'(o_Grant), 32'h1);
    drive(3'b000, 3'b001);
    drive(3'b000, 3'b000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dma_bus_arbiter.md
Name: dma_bus_arbiter

Overview:
Round-robin arbiter for the shared BRAM/system bus. The requesters are the CPU, the UART-RX DMA channel and the UART-TX DMA channel. It drives the i_Bus_Grant inputs of the DMA_controller_IO instances and the CPU stall/grant. Grants are held until release, with a bounded-hold preemption so a long DMA burst cannot starve the other requesters. A one-cycle bus turnaround is enforced between owners.

Parameters:
NUM_REQ, 3, number of requesters (index 0 = CPU, 1 = DMA RX, 2 = DMA TX); legal range 2..8.
MAX_HOLD, 16, max grant cycles before preemption when another requester is pending; 0 disables preemption.

Ports:
i_Clock  input  1  system clock, all logic on rising edge.
i_Reset  input  1  synchronous, active-high reset.
i_Req  input  NUM_REQ  level request per requester; held while the bus is wanted.
i_Done  input  NUM_REQ  one-cycle release pulse from a requester.
o_Grant  output  NUM_REQ  registered one-hot grant; all-zero when the bus is idle.
o_Grant_Valid  output  1  OR of o_Grant, registered.
o_Grant_Id  output  ID_W  index of the current owner; ID_W = max(1, clog2(NUM_REQ)).
o_Preempt  output  NUM_REQ  one-cycle pulse to the owner whose grant is being revoked by timeout.

Behaviour:
- Reset state (edge with i_Reset=1):
  - o_Grant=0, o_Grant_Valid=0, o_Grant_Id=0, o_Preempt=0.
  - State IDLE, hold counter 0, last-granted pointer = NUM_REQ-1, so index 0 wins the first tie.
- All outputs are registered. No combinational path from i_Req to o_Grant.
- Priority pick:
  - Search order is last+1, last+2, ... modulo NUM_REQ.
  - The first index with i_Req=1 wins.
  - A just-released owner is searched last, but can win if it is the only requester.
- IDLE:
  - If any i_Req is high, pick, then on the next edge set o_Grant/o_Grant_Id, update last, clear the counter, go to GRANT.
  - Latency from i_Req rising to o_Grant visible: 1 clock.
- GRANT:
  - The counter increments each cycle and saturates at MAX_HOLD.
  - Leave to RELEASE when i_Done[owner]=1 or i_Req[owner]=0 (normal release).
  - Otherwise, when MAX_HOLD≠0, counter = MAX_HOLD-1, and any other i_Req is high: pulse o_Preempt[owner] for that one edge, then go to RELEASE.
  - With no other requester pending, the grant is kept indefinitely. The counter saturates, and preemption fires as soon as a competitor appears.
- RELEASE:
  - o_Grant=0 for exactly one cycle (turnaround).
  - Perform the pick in this cycle. Next state is GRANT with the new owner if any request is pending, else IDLE.
  - The gap between owners is therefore exactly 1 cycle.
- Simultaneous events:
  - i_Done[owner] together with a timeout: normal release, o_Preempt stays 0.
  - i_Done/i_Req changes on non-owners do not affect the current grant. i_Done to a non-owner is ignored.
- A preempted requester that keeps i_Req high re-enters round-robin as the lowest priority.
- Reset mid-grant: grant and all outputs are zero after the reset edge. Arbitration restarts from index 0.
- At most one o_Grant bit is ever set. o_Grant and o_Preempt are never both set in the same cycle for different owners.

Decomposition:
- Package dma_arb_pkg:
  - State encodings ST_IDLE, ST_GRANT, ST_RELEASE (2 bits).
  - Requester index constants REQ_CPU=0, REQ_DMA_RX=1, REQ_DMA_TX=2.
  - ID width function.
- One natural sub-module, rr_priority_picker: combinational rotate/priority-encode/unrotate. Inputs are the request vector and last pointer; outputs are the one-hot winner, winner index and any-valid.

Test Plan:
1. Reset, then i_Req=3'b010 held → o_Grant=3'b010, o_Grant_Id=1 one cycle later; i_Done[1] pulse → o_Grant=0 one cycle later, IDLE.
2. After reset, i_Req=3'b101 simultaneously → grant 3'b001 first; i_Done[0] → one zero cycle, then 3'b100; i_Done[2] with i_Req[0] still high → zero cycle, then 3'b001.
3. MAX_HOLD=8: req1 granted, req2 raised on grant cycle 3 → o_Preempt=3'b010 on grant cycle 8, one zero cycle, then o_Grant=3'b100; req1 still high → regranted after req2 releases.
4. MAX_HOLD=8: req0 alone held 40 cycles → o_Grant=3'b001 throughout, o_Preempt never asserted; req1 raised at cycle 40 → preempt pulse on the next cycle (counter saturated).
5. MAX_HOLD=8: i_Done[owner] in the same cycle as the timeout with a competitor pending → o_Preempt stays 0, normal handover.
6. i_Reset asserted during GRANT of requester 2 with all three requesting → all outputs 0 after the edge; after deassertion the first grant goes to index 0.
